mac_acc_drain: RTL
==================

MAC_ACC_DRAIN -- requirements
Module: mac_acc_drain

Interface
REQ-001 Parameter LEN_W, default 8, width of the transfer-length field and beat counter.
REQ-002 CLK  input  1  clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin one accumulation job; sampled only in IDLE.
REQ-005 len  input  LEN_W  number of MAC results to accumulate; sampled with start.
REQ-006 in_data  input  64  MAC result word from the upstream MAC stage.
REQ-007 in_rdy  input  1  upstream result available; connects to the MAC stage's result-ready output.
REQ-008 in_en  output  1  pop strobe to the upstream MAC stage; connects to its result-enable input.
REQ-009 out_sum  output  64  accumulated dot-product.
REQ-010 out_valid  output  1  out_sum is valid.
REQ-011 out_ready  input  1  consumer accepts out_sum.
REQ-012 busy  output  1  high in every state other than IDLE.
REQ-013 ovf  output  1  sticky flag: a carry out of bit 63 occurred during the current job.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACC and DONE.
REQ-015 IDLE, start=1, len!=0 -> ACC; the block SHALL latch len, clear sum to 0, clear the beat counter and clear ovf.
REQ-016 IDLE, start=1, len=0 -> DONE; the block SHALL clear sum and ovf, and out_sum SHALL be 0.
REQ-017 in_en SHALL equal in_rdy while in ACC and SHALL be 0 in every other state, so a pop occurs only when in_rdy=1 and the state is ACC.
REQ-018 On each pop the block SHALL set sum <= sum + in_data (64-bit), increment the beat counter, and set ovf if the addition produces a carry out of bit 63.
REQ-019 A pop that brings the beat count to the latched len SHALL move the FSM to DONE; out_valid SHALL rise the cycle after that pop and out_sum SHALL already include that final addend.
REQ-020 In DONE, out_valid=1 and out_sum/ovf SHALL be held stable until out_ready=1; on out_valid and out_ready both high the FSM SHALL return to IDLE.
REQ-021 start SHALL be ignored outside IDLE; a start asserted on the DONE-handshake cycle SHALL be ignored, and no new job SHALL begin before the next IDLE cycle.
REQ-022 A cycle in ACC with in_rdy=0 SHALL cause no pop and no change of sum, counter or ovf; there SHALL be no timeout.
REQ-023 len=2^LEN_W-1 SHALL complete without counter wrap; the counter SHALL be LEN_W bits.
REQ-024 out_sum SHALL show the live sum in every state; consumers SHALL use it only while out_valid=1.

Reset
REQ-025 While RST=1 at a clock edge: the state SHALL go to IDLE, and sum, counter, latched len and ovf SHALL go to 0.
REQ-026 Outputs after reset SHALL be: in_en=0, out_valid=0, busy=0, ovf=0, out_sum=0.
REQ-027 A reset in ACC or DONE SHALL abandon the job with no further pops; any MAC results left upstream are not drained.

Configuration
REQ-028 Macro MAC_ACC_SAT_EN defined: on a pop whose addition carries out, sum SHALL saturate to 64'hFFFF_FFFF_FFFF_FFFF and stay there for the rest of the job; ovf SHALL still set.
REQ-029 Macro MAC_ACC_SAT_EN undefined: sum SHALL wrap modulo 2^64, and ovf SHALL set exactly as in REQ-018.

Verification
REQ-030 start, len=3; in_rdy=1 with in_data 10, 20, 30 on consecutive cycles -> exactly 3 in_en pulses; out_valid the cycle after the third pop; out_sum=60, ovf=0.
REQ-031 start, len=0 -> DONE on the next cycle with out_valid=1, out_sum=0, in_en never asserted.
REQ-032 len=2, in_rdy toggling 1,0,0,1 -> pops only on the in_rdy=1 cycles; out_sum equals the sum of the two accepted words; out_ready held 0 for 5 cycles -> out_valid and out_sum stable throughout.
REQ-033 len=2, in_data 64'hFFFF_FFFF_FFFF_FFFF then 2 -> ovf=1; out_sum=1 without MAC_ACC_SAT_EN, 64'hFFFF_FFFF_FFFF_FFFF with it.
REQ-034 RST asserted after 1 of 4 pops -> next cycle busy=0, out_valid=0, in_en=0, out_sum=0; a new start with len=1 and in_data=5 -> out_sum=5.
REQ-035 start held high through the DONE handshake -> returns to IDLE, and the new job starts only on the following IDLE cycle with a fresh sum.

Source files
------------

// File: rtl/mac_acc_drain.sv
// Drains LEN MAC results from the upstream MAC stage and accumulates them into a 64-bit sum.
// Define MAC_ACC_SAT_EN to saturate the sum on carry-out instead of wrapping.
module mac_acc_drain #(
    parameter int LEN_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [63:0]      in_data,
    input  logic             in_rdy,
    output logic             in_en,
    output logic [63:0]      out_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             ovf
);

    localparam int DATA_W = 64;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] sum;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_nxt;
    logic [LEN_W-1:0]  len_q;
    logic              ovf_q;

    function automatic logic carry_out(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a + b) < a;
    endfunction

    // Once saturated at all-ones, any further non-zero addend carries again, so the sum stays pinned.
    function automatic logic [DATA_W-1:0] acc_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MAC_ACC_SAT_EN
        if (carry_out(a, b))
            return '1;
        return a + b;
`else
        return a + b;
`endif
    endfunction

    assign cnt_nxt = cnt + LEN_W'(1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            sum   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sum   <= '0;
                        cnt   <= '0;
                        ovf_q <= 1'b0;
                        len_q <= len;
                        state <= (len == '0) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (in_rdy) begin
                        sum <= acc_add(sum, in_data);
                        cnt <= cnt_nxt;
                        if (carry_out(sum, in_data))
                            ovf_q <= 1'b1;
                        if (cnt_nxt == len_q)
                            state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The pop strobe is a direct gate of in_rdy so a result is taken in the same cycle it is offered.
    assign in_en     = (state == ACC) && in_rdy;
    assign out_sum   = sum;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign ovf       = ovf_q;

endmodule
